tty_text_writer: RTL and testbench
==================================

Name: tty_text_writer

Overview:
- Upstream feeder for the VGA text display: converts a byte stream (ASCII with control codes) into single-byte writes to the 80x30 character buffer.
- Buffer addresses are row*80+col.
- The block tracks a cursor and interprets CR, LF, BS and FF.
- When the cursor passes the bottom row it wraps to row 0 and blanks that row. The character buffer is write-only, so the block does not scroll.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- FILL, 8'h20, byte written when clearing.
- ADDR_W, 16, buffer address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- char_valid  in  1  input byte is valid
- char_data  in  8  input byte
- char_ready  out  1  block can accept a byte this cycle
- buf_we  out  1  buffer write strobe, one cycle per write
- buf_addr  out  ADDR_W  buffer write address
- buf_data  out  8  buffer write data
- cursor_addr  out  ADDR_W  current cursor address (row*COLS+col)
- busy  out  1  a clear is in progress

Behaviour:
- One clock, `clk`; reset is synchronous and active-high on `reset`.
- Reset values:
  - buf_we=0, buf_addr=0, buf_data=0.
  - Cursor col=0, row=0, row_base=0, so cursor_addr=0.
  - char_ready=0.
  - busy=1 from the first cycle after reset, because reset always starts CLR_ALL.
- All outputs are registered.
- Addressing: row_base holds row*COLS and is maintained by adding or subtracting COLS; no multiplier. cursor_addr = row_base + col.
- States: IDLE, CLR_ROW, CLR_ALL.
- IDLE:
  - char_ready=1.
  - A byte is accepted on a rising edge where char_valid & char_ready.
- Printable byte (0x20..0x7E, or >=0x80):
  - Write at cursor: buf_we=1, buf_addr=cursor_addr, buf_data=char_data in the cycle after acceptance (latency 1).
  - Then advance the cursor. If col==COLS-1, set col=0 and perform a line advance.
- 0x0D (CR): col=0, no write.
- 0x0A (LF): col=0 plus a line advance, no write.
- 0x08 (BS): if col>0, col-=1 and write FILL at the new position. At col==0, no-op.
- 0x0C (FF): go to CLR_ALL. Cursor goes to 0,0.
- Any other byte <0x20, and 0x7F: accepted, no write, cursor unchanged.
- Line advance:
  - If row<ROWS-1: row+=1, row_base+=COLS.
  - Otherwise: row=0, row_base=0, and go to CLR_ROW.
- CLR_ROW:
  - char_ready=0, busy=1.
  - Writes FILL to row_base+0 .. row_base+COLS-1, one per cycle, with consecutive buf_we pulses.
  - Returns to IDLE after the last write. Total of COLS cycles with busy=1.
- CLR_ALL:
  - Same as CLR_ROW but covers addresses 0..ROWS*COLS-1 (2400 writes).
  - Entered on reset and on FF.
- Simultaneous events: char_valid while busy is not accepted, and the byte must be held by the source. No byte is ever dropped or duplicated.
- Reset mid-clear: the clear aborts, the cursor returns home, and a fresh CLR_ALL starts from address 0.
- buf_addr never reaches or exceeds ROWS*COLS.

Optional Feature:
- Macro TTY_TAB_EN.
- Defined:
  - 0x09 (TAB) enters state TAB, with char_ready=0.
  - TAB writes FILL at the cursor and advances col, repeating until col is a multiple of 8. This is at least one write.
  - If col wraps past COLS-1, a normal line advance applies and TAB ends there.
- Undefined: 0x09 is treated as an ignored control byte.

Decomposition:
- Shared package tty_pkg holds:
  - the state enum (IDLE, CLR_ROW, CLR_ALL, TAB);
  - control-code constants CH_BS, CH_TAB, CH_LF, CH_FF, CH_CR, CH_DEL;
  - default COLS/ROWS/FILL.
- One natural sub-module, tty_cursor: holds col, row, row_base and the advance/home/backspace operations, and produces cursor_addr plus a wrap flag.
- The FSM and write port stay in the top module.

Test Plan:
- Reset for 1 cycle, then idle:
  - 2400 buf_we pulses, addr 0..2399, data 0x20.
  - busy then falls, char_ready=1, cursor_addr=0.
- After the clear, send 'A','B' (0x41,0x42):
  - Writes (0,0x41),(1,0x42), each one cycle after acceptance.
  - cursor_addr=2.
- Send 79 'x' then 'y':
  - 'y' written at addr 79.
  - cursor_addr=80.
  - 0x0D then returns cursor_addr to 80; 0x0A moves it to 160.
- With cursor at row 29 col 5, send 0x0A:
  - cursor_addr=0.
  - 80 writes of 0x20 to addr 0..79.
  - char_ready=0 for those 80 cycles, with char_valid held by the source.
  - The next byte 'Z' is written at addr 0.
- BS at col 3 of row 2 (addr 163) writes 0x20 at 162 and sets cursor_addr=162. BS at col 0 produces no write.
- Assert reset midway through an FF clear (at write 1000): a new clear restarts at addr 0 and completes 2400 writes.
- With TTY_TAB_EN defined, TAB at col 3 writes 0x20 at cols 3..7 and leaves col=8.

Source files
------------

// File: rtl/tty_pkg.sv
// Shared definitions for the TTY text writer: FSM states, control codes and
// default screen geometry.
package tty_pkg;

    localparam int unsigned TTY_COLS = 80;
    localparam int unsigned TTY_ROWS = 30;
    localparam logic [7:0]  TTY_FILL = 8'h20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2,
        TAB     = 2'd3
    } tty_state_e;

    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_DEL = 8'h7F;

    // Bytes that are drawn as glyphs rather than interpreted.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b != CH_DEL);
    endfunction

endpackage

// File: rtl/tty_cursor.sv
// Cursor tracker: column, row and row_base (row*COLS kept by add/subtract),
// plus a registered linear cursor address. wrap_o_c flags a line advance
// out of the bottom row in the current cycle.
module tty_cursor import tty_pkg::*; #(
    parameter int unsigned COLS   = TTY_COLS,
    parameter int unsigned ROWS   = TTY_ROWS,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              home_i,
    input  logic              adv_i,
    input  logic              cr_i,
    input  logic              lf_i,
    input  logic              bs_i,
    output logic [ADDR_W-1:0] col_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wrap_o_c
);

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              line_c;

    // Next cursor position for the requested operation.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        base_d = base_q;
        addr_d = addr_q;
        line_c = 1'b0;
        if (home_i) begin
            col_d  = '0;
            row_d  = '0;
            base_d = '0;
            addr_d = '0;
        end else if (adv_i) begin
            if (col_q == COL_LAST) begin
                col_d  = '0;
                line_c = 1'b1;
            end else begin
                col_d  = col_q + ADDR_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end else if (cr_i) begin
            col_d  = '0;
            addr_d = base_q;
        end else if (lf_i) begin
            col_d  = '0;
            line_c = 1'b1;
        end else if (bs_i && (col_q != '0)) begin
            col_d  = col_q - ADDR_W'(1);
            addr_d = addr_q - ADDR_W'(1);
        end
        if (line_c) begin
            if (row_q != ROW_LAST) begin
                row_d  = row_q + ADDR_W'(1);
                base_d = base_q + COLS_A;
                addr_d = base_q + COLS_A;
            end else begin
                row_d  = '0;
                base_d = '0;
                addr_d = '0;
            end
        end
    end

    assign wrap_o_c = line_c && (row_q == ROW_LAST);
    assign col_o    = col_q;
    assign addr_o   = addr_q;

    // Cursor registers; reset homes the cursor.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            base_q <= base_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/tty_text_writer.sv
// TTY text writer: turns a byte stream into single-byte writes to an
// 80x30 write-only character buffer. Wraps to row 0 (blanking it) instead
// of scrolling. Optional macro TTY_TAB_EN enables tab stops every 8 columns.
module tty_text_writer import tty_pkg::*; #(
    parameter int unsigned COLS   = TTY_COLS,
    parameter int unsigned ROWS   = TTY_ROWS,
    parameter logic [7:0]  FILL   = TTY_FILL,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_data,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ROW_END = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] SCR_END = ADDR_W'(ROWS * COLS - 1);

    tty_state_e        state_q;
    logic [ADDR_W-1:0] clr_q;
    logic [ADDR_W-1:0] clr_end_c;
    logic [ADDR_W-1:0] col;
    logic              take_c, print_c, tab_c;
    logic              home_c, adv_c, cr_c, lf_c, bs_c, wrap_c;

`ifdef TTY_TAB_EN
    assign tab_c = (char_data == CH_TAB);
`else
    assign tab_c = 1'b0;
`endif

    // Decode the accepted byte into cursor operations.
    always_comb begin
        take_c    = char_valid && char_ready && (state_q == IDLE);
        print_c   = is_printable(char_data);
        home_c    = 1'b0;
        adv_c     = 1'b0;
        cr_c      = 1'b0;
        lf_c      = 1'b0;
        bs_c      = 1'b0;
        clr_end_c = (state_q == CLR_ALL) ? SCR_END : ROW_END;
        if (take_c) begin
            if (print_c) begin
                adv_c = 1'b1;
            end else begin
                home_c = (char_data == CH_FF);
                cr_c   = (char_data == CH_CR);
                lf_c   = (char_data == CH_LF);
                bs_c   = (char_data == CH_BS);
            end
        end
        if (state_q == TAB) begin
            adv_c = 1'b1;
        end
    end

    tty_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk_i    (clk),
        .reset_i  (reset),
        .home_i   (home_c),
        .adv_i    (adv_c),
        .cr_i     (cr_c),
        .lf_i     (lf_c),
        .bs_i     (bs_c),
        .col_o    (col),
        .addr_o   (cursor_addr),
        .wrap_o_c (wrap_c)
    );

    // Control FSM and registered buffer write port. Wrapping always lands on
    // row 0, so a row clear always starts at address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLR_ALL;
            clr_q      <= '0;
            char_ready <= 1'b0;
            busy       <= 1'b1;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
        end else begin
            buf_we <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_c) begin
                        if (print_c) begin
                            buf_we   <= 1'b1;
                            buf_addr <= cursor_addr;
                            buf_data <= char_data;
                        end else if ((char_data == CH_BS) && (col != '0)) begin
                            buf_we   <= 1'b1;
                            buf_addr <= cursor_addr - ADDR_W'(1);
                            buf_data <= FILL;
                        end
                        if (char_data == CH_FF) begin
                            state_q    <= CLR_ALL;
                            clr_q      <= '0;
                            char_ready <= 1'b0;
                            busy       <= 1'b1;
                        end else if (wrap_c) begin
                            state_q    <= CLR_ROW;
                            clr_q      <= '0;
                            char_ready <= 1'b0;
                            busy       <= 1'b1;
                        end else if (tab_c) begin
                            state_q    <= TAB;
                            char_ready <= 1'b0;
                        end
                    end
                end
                CLR_ROW, CLR_ALL: begin
                    buf_we   <= 1'b1;
                    buf_addr <= clr_q;
                    buf_data <= FILL;
                    if (clr_q == clr_end_c) begin
                        state_q    <= IDLE;
                        char_ready <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        clr_q <= clr_q + ADDR_W'(1);
                    end
                end
                TAB: begin
                    buf_we   <= 1'b1;
                    buf_addr <= cursor_addr;
                    buf_data <= FILL;
                    if (wrap_c) begin
                        state_q <= CLR_ROW;
                        clr_q   <= '0;
                        busy    <= 1'b1;
                    end else if ((col[2:0] == 3'b111) || (col == ROW_END)) begin
                        state_q    <= IDLE;
                        char_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    char_ready <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tty_text_writer.sv
// Testbench for tty_text_writer: directed scenarios plus a randomized byte
// stream, scored against a screen/cursor model that predicts every write.
module tb_tty_text_writer;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        buf_we;
    logic [15:0] buf_addr;
    logic [7:0]  buf_data;
    logic [15:0] cursor_addr;
    logic        busy;

    always #5 clk = ~clk;

    tty_text_writer dut (
        .clk         (clk),
        .reset       (reset),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .buf_we      (buf_we),
        .buf_addr    (buf_addr),
        .buf_data    (buf_data),
        .cursor_addr (cursor_addr),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mcol, mrow;
    int exp_a[$];
    int exp_d[$];
    int pops = 0;
    int last_wait;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_print(input logic [7:0] b);
        return (b >= 8'h20) && (b != 8'h7F);
    endfunction

    function automatic void push_w(input int a, input int d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endfunction

    function automatic void push_clear(input int n);
        for (int i = 0; i < n; i++) push_w(i, 32'h20);
    endfunction

    function automatic void line_adv();
        if (mrow < ROWS - 1) mrow++;
        else begin
            mrow = 0;
            push_clear(COLS);
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (is_print(b)) begin
            push_w(mrow * COLS + mcol, int'(b));
            mcol++;
            if (mcol == COLS) begin
                mcol = 0;
                line_adv();
            end
        end else begin
            case (b)
                8'h0D: mcol = 0;
                8'h0A: begin mcol = 0; line_adv(); end
                8'h08: if (mcol > 0) begin mcol--; push_w(mrow * COLS + mcol, 32'h20); end
                8'h0C: begin mcol = 0; mrow = 0; push_clear(COLS * ROWS); end
`ifdef TTY_TAB_EN
                8'h09: begin
                    bit done;
                    done = 1'b0;
                    while (!done) begin
                        push_w(mrow * COLS + mcol, 32'h20);
                        mcol++;
                        if (mcol == COLS) begin
                            mcol = 0;
                            line_adv();
                            done = 1'b1;
                        end else if (mcol % 8 == 0) begin
                            done = 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    endfunction

    // ---------------- write monitor ----------------
    always @(negedge clk) begin
        if (buf_we === 1'b1) begin
            check("wr_expected", 32'(exp_a.size() > 0), 32'd1);
            if (exp_a.size() > 0) begin
                int a, d;
                a = exp_a.pop_front();
                d = exp_d.pop_front();
                check("wr_addr", 32'(buf_addr), a);
                check("wr_data", 32'(buf_data), d);
            end
            check("addr_range", 32'(buf_addr < 16'd2400), 32'd1);
            pops++;
        end
    end

    // ---------------- driver ----------------
    // Called at a falling edge; holds the byte until accepted and returns at
    // the falling edge after acceptance.
    task automatic send(input logic [7:0] b);
        int n;
        bit wr;
        n = 0;
        char_valid = 1'b1;
        char_data  = b;
        while (char_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (n >= 5000) begin
            check("ready_timeout", n, 0);
            char_valid = 1'b0;
            return;
        end
        wr = is_print(b) || (b == 8'h08 && mcol > 0);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        model_byte(b);
        @(negedge clk);
        check("wr_latency", 32'(buf_we), 32'(wr));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(char_ready === 1'b1 && busy === 1'b0 && exp_a.size() == 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 20000), 32'd1);
        check("cursor", 32'(cursor_addr), mrow * COLS + mcol);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 99);
        if (r < 60) begin
            b = 8'($urandom_range(32, 255));
            if (b == 8'h7F) b = 8'h61;
        end else if (r < 72) b = 8'h0A;
        else if (r < 78) b = 8'h0D;
        else if (r < 86) b = 8'h08;
        else if (r < 88) b = 8'h0C;
        else if (r < 93) b = 8'h09;
        else if (r < 96) b = 8'h7F;
        else b = 8'($urandom_range(0, 31));
        return b;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int target, n;
        reset      = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        mcol = 0;
        mrow = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_we", 32'(buf_we), 32'd0);
        check("rst_addr", 32'(buf_addr), 32'd0);
        check("rst_data", 32'(buf_data), 32'd0);
        check("rst_cursor", 32'(cursor_addr), 32'd0);
        check("rst_ready", 32'(char_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        push_clear(COLS * ROWS);
        reset = 1'b0;
        wait_idle();
        check("idle_ready", 32'(char_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // "AB" at home
        send(8'h41);
        send(8'h42);
        wait_idle();
        check("ab_cursor", 32'(cursor_addr), 32'd2);

        // fill a row: 79 x then y at column 79
        send(8'h0D);
        repeat (79) send(8'h78);
        send(8'h79);
        check("eol_cursor", 32'(cursor_addr), 32'd80);
        send(8'h0D);
        check("cr_cursor", 32'(cursor_addr), 32'd80);
        send(8'h0A);
        check("lf_cursor", 32'(cursor_addr), 32'd160);

        // bottom-row wrap with a held byte
        repeat (27) send(8'h0A);
        repeat (5) send(8'h63);
        check("r29_cursor", 32'(cursor_addr), 32'd2325);
        send(8'h0A);
        check("wrap_cursor", 32'(cursor_addr), 32'd0);
        check("wrap_ready", 32'(char_ready), 32'd0);
        check("wrap_busy", 32'(busy), 32'd1);
        send(8'h5A);
        check("held_cycles", last_wait, 32'd80);
        wait_idle();

        // backspace
        send(8'h0A);
        send(8'h0A);
        repeat (3) send(8'h63);
        check("bs_pre", 32'(cursor_addr), 32'd163);
        send(8'h08);
        check("bs_cursor", 32'(cursor_addr), 32'd162);
        send(8'h0D);
        send(8'h08);
        check("bs_col0", 32'(cursor_addr), 32'd160);
        wait_idle();

        // randomized stream
        for (int i = 0; i < 400; i++) begin
            send(rand_byte());
            if (i % 25 == 24) wait_idle();
        end
        wait_idle();

        // reset in the middle of a form-feed clear
        send(8'h0C);
        target = pops + 1000;
        n = 0;
        while (pops < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("ff_progress", 32'(n < 5000), 32'd1);
        #1;
        reset = 1'b1;
        exp_a.delete();
        exp_d.delete();
        mcol = 0;
        mrow = 0;
        push_clear(COLS * ROWS);
        @(negedge clk);
        check("mid_rst_we", 32'(buf_we), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_cursor", 32'(cursor_addr), 32'd0);
        #1;
        reset = 1'b0;
        wait_idle();

`ifdef TTY_TAB_EN
        repeat (3) send(8'h61);
        send(8'h09);
        wait_idle();
        check("tab_cursor", 32'(cursor_addr), 32'd8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
